// File: rtl/profile_ci_pkg.sv
// Shared encodings for the profiling custom-instruction unit: opcodes, valueA
// field layout, event-source selects and the STATUS word layout.
package profile_ci_pkg;

   localparam int IDX_LSB = 0;
   localparam int IDX_W   = 4;
   localparam int OP_LSB  = 4;
   localparam int OP_W    = 4;

   localparam logic [OP_W-1:0] OP_READ_LO     = 4'd0;
   localparam logic [OP_W-1:0] OP_READ_HI     = 4'd1;
   localparam logic [OP_W-1:0] OP_ENABLE      = 4'd2;
   localparam logic [OP_W-1:0] OP_DISABLE     = 4'd3;
   localparam logic [OP_W-1:0] OP_CLEAR       = 4'd4;
   localparam logic [OP_W-1:0] OP_SELECT      = 4'd5;
   localparam logic [OP_W-1:0] OP_SNAPSHOT    = 4'd6;
   localparam logic [OP_W-1:0] OP_READ_SHADOW = 4'd7;
   localparam logic [OP_W-1:0] OP_STATUS      = 4'd8;

   localparam int              SRC_W     = 4;
   localparam logic [SRC_W-1:0] SRC_CYCLE = 4'd0;
   localparam logic [SRC_W-1:0] SRC_NEVER = 4'hF;

   localparam int STATUS_EN_LSB  = 0;
   localparam int STATUS_OVF_LSB = 16;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [IDX_W-1:0] idx;
   } ci_cmd_t;

endpackage

// File: rtl/profile_counter_slice.sv
// One profiling counter: source select register, source mux, wrap/sticky overflow,
// and a shadow copy when PROFILE_CI_SNAPSHOT_EN is defined (else shadow_o is live).
module profile_counter_slice
   import profile_ci_pkg::*;
#(
   parameter int W          = 32,
   parameter int NUM_EVENTS = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable_i,
   input  logic [NUM_EVENTS-1:0] events_i,
   input  logic                  sel_we_i,
   input  logic [SRC_W-1:0]      sel_i,
   input  logic                  clr_i,
   input  logic                  snap_i,
   output logic [W-1:0]          cnt_o,
   output logic                  ovf_o,
   output logic [W-1:0]          shadow_o
);

   logic [SRC_W-1:0] src_q;
   logic [W-1:0]     cnt_q;
   logic             ovf_q;
   logic             hit;

   // Selects outside 1..NUM_EVENTS (other than SRC_CYCLE) never count.
   always_comb begin
      hit = (src_q == SRC_CYCLE);
      for (int k = 0; k < NUM_EVENTS; k++)
         if (src_q == SRC_W'(k + 1)) hit = events_i[k];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         src_q <= SRC_CYCLE;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (sel_we_i) src_q <= sel_i;
         if (clr_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else if (enable_i && hit) begin
            cnt_q <= cnt_q + W'(1);
            if (&cnt_q) ovf_q <= 1'b1;
         end
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

`ifdef PROFILE_CI_SNAPSHOT_EN
   logic [W-1:0] shadow_q;

   always_ff @(posedge clock) begin
      if (reset)       shadow_q <= '0;
      else if (snap_i) shadow_q <= cnt_q;
   end

   assign shadow_o = shadow_q;
`else
   logic unused_snap;
   assign unused_snap = snap_i;
   assign shadow_o    = cnt_q;
`endif

endmodule

// File: rtl/profile_ci_multi.sv
// Profiling custom-instruction unit: command decode, enable mask and result mux
// over NUM_COUNTERS slices. Shadow snapshots exist only with PROFILE_CI_SNAPSHOT_EN.
module profile_ci_multi
   import profile_ci_pkg::*;
#(
   parameter logic [7:0] CUSTOM_ID     = 8'd8,
   parameter int         NUM_COUNTERS  = 8,
   parameter int         COUNTER_WIDTH = 32,
   parameter int         NUM_EVENTS    = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            ciN,
   input  logic [31:0]           valueA,
   input  logic [31:0]           valueB,
   input  logic [NUM_EVENTS-1:0] events,
   output logic                  done,
   output logic [31:0]           result
);

   localparam int NC = NUM_COUNTERS;
   localparam int W  = COUNTER_WIDTH;

   ci_cmd_t              cmd;
   logic                 acc;
   logic [NC-1:0]        mask;
   logic [NC-1:0]        en_q, en_d;
   logic [NC-1:0]        ovf;
   logic [NC-1:0][W-1:0] cnt, shd;
   logic [W-1:0]         sel_cnt, sel_shd;
   logic [63:0]          cnt_ext;
   logic [31:0]          status, res_d;
   logic                 done_q;
   logic [31:0]          result_q;
   logic                 unused_bits;

   assign acc         = start && (ciN == CUSTOM_ID);
   assign cmd.op      = valueA[OP_LSB +: OP_W];
   assign cmd.idx     = valueA[IDX_LSB +: IDX_W];
   assign mask        = valueB[NC-1:0];
   assign unused_bits = &{1'b0, valueA[31:OP_LSB+OP_W], valueB[31:NC]};

   for (genvar i = 0; i < NC; i++) begin : g_slice
      profile_counter_slice #(.W(W), .NUM_EVENTS(NUM_EVENTS)) u_slice (
         .clock    (clock),
         .reset    (reset),
         .enable_i (en_q[i]),
         .events_i (events),
         .sel_we_i (acc && cmd.op == OP_SELECT && cmd.idx == IDX_W'(i)),
         .sel_i    (valueB[SRC_W-1:0]),
         .clr_i    (acc && cmd.op == OP_CLEAR && mask[i]),
         .snap_i   (acc && cmd.op == OP_SNAPSHOT),
         .cnt_o    (cnt[i]),
         .ovf_o    (ovf[i]),
         .shadow_o (shd[i])
      );
   end

   // Mask updates land at T+1, so the increment at T still sees the old enable.
   always_comb begin
      en_d = en_q;
      if (acc && cmd.op == OP_ENABLE)  en_d = en_q | mask;
      if (acc && cmd.op == OP_DISABLE) en_d = en_q & ~mask;
   end

   // Out-of-range indices match no slice and read back as 0.
   always_comb begin
      sel_cnt = '0;
      sel_shd = '0;
      for (int i = 0; i < NC; i++)
         if (cmd.idx == IDX_W'(i)) begin
            sel_cnt = cnt[i];
            sel_shd = shd[i];
         end
   end

   always_comb begin
      cnt_ext = 64'(sel_cnt);
      status  = '0;
      status[STATUS_EN_LSB  +: NC] = en_q;
      status[STATUS_OVF_LSB +: NC] = ovf;
      res_d   = '0;
      case (cmd.op)
         OP_READ_LO:     res_d = cnt_ext[31:0];
         OP_READ_HI:     res_d = cnt_ext[63:32];
         OP_READ_SHADOW: res_d = 32'(sel_shd);
         OP_STATUS:      res_d = status;
         default:        res_d = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         en_q     <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         en_q     <= en_d;
         done_q   <= acc;
         result_q <= acc ? res_d : '0;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_profile_ci_multi.sv
// Directed bench for profile_ci_multi (4 counters of 8 bits, 4 events); expected
// values are hand-counted clock edges per counter.
module tb_profile_ci_multi;
   import profile_ci_pkg::*;

   logic        clock = 1'b0;
   logic        reset, start;
   logic [7:0]  ciN;
   logic [31:0] valueA, valueB;
   logic [3:0]  events;
   logic        done;
   logic [31:0] result;

   int          total = 0;
   int          bad   = 0;
   logic        d_s;
   logic [31:0] r_s;

   profile_ci_multi #(
      .CUSTOM_ID(8'd8), .NUM_COUNTERS(4), .COUNTER_WIDTH(8), .NUM_EVENTS(4)
   ) u_dut (
      .clock(clock), .reset(reset), .start(start), .ciN(ciN),
      .valueA(valueA), .valueB(valueB), .events(events),
      .done(done), .result(result)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one command for exactly one clock edge; capture done/result after it.
   task automatic cmd(input logic [7:0] ci, input logic [3:0] op, input logic [3:0] idx,
                      input logic [31:0] b);
      start  = 1'b1;
      ciN    = ci;
      valueA = {24'h0, op, idx};
      valueB = b;
      @(posedge clock);
      @(negedge clock);
      d_s    = done;
      r_s    = result;
      start  = 1'b0;
      ciN    = '0;
      valueA = '0;
      valueB = '0;
   endtask

   task automatic rd(input string tag, input logic [3:0] op, input logic [3:0] idx,
                     input logic [31:0] exp);
      cmd(8'd8, op, idx, 32'h0);
      chk({tag, "_dn"}, 32'(d_s), 32'd1);
      chk(tag, r_s, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; ciN = '0; valueA = '0; valueB = '0; events = '0;
      repeat (2) @(negedge clock);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res", result, 32'd0);
      reset = 1'b0;
      rd("rst_status", OP_STATUS, 4'd0, 32'h0);

      // counter0 counts cycles; enable edge itself does not count
      cmd(8'd8, OP_SELECT, 4'd0, 32'h0);
      chk("sel_dn", 32'(d_s), 32'd1);
      chk("sel_res", r_s, 32'd0);
      cmd(8'd8, OP_ENABLE, 4'd0, 32'h1);
      repeat (100) @(negedge clock);
      rd("lo100", OP_READ_LO, 4'd0, 32'd100);
      @(negedge clock);
      chk("after_dn", 32'(done), 32'd0);
      chk("after_res", result, 32'd0);
      cmd(8'd8, OP_DISABLE, 4'd0, 32'h1);
      rd("lo_dis", OP_READ_LO, 4'd0, 32'd103);
      cmd(8'd8, OP_CLEAR, 4'd0, 32'h1);
      cmd(8'd8, OP_ENABLE, 4'd0, 32'h1);
      rd("en_t", OP_READ_LO, 4'd0, 32'd0);
      rd("en_t1", OP_READ_LO, 4'd0, 32'd1);
      cmd(8'd8, OP_DISABLE, 4'd0, 32'h1);

      // counter1 on events[0]; events[3] high too must not leak in
      cmd(8'd8, OP_SELECT, 4'd1, 32'h1);
      cmd(8'd8, OP_ENABLE, 4'd0, 32'h2);
      events = 4'b1001;
      repeat (37) @(negedge clock);
      events = 4'b0000;
      rd("ev37", OP_READ_LO, 4'd1, 32'd37);
      cmd(8'd8, OP_DISABLE, 4'd0, 32'h2);
      events = 4'b0001;
      repeat (10) @(negedge clock);
      events = 4'b0000;
      rd("ev_dis", OP_READ_LO, 4'd1, 32'd37);

      // counter2 wraps at 8 bits; CLEAR beats the same-edge increment
      cmd(8'd8, OP_ENABLE, 4'd0, 32'h4);
      repeat (260) @(negedge clock);
      rd("wrap_lo", OP_READ_LO, 4'd2, 32'd4);
      rd("wrap_st", OP_STATUS, 4'd0, 32'h0004_0004);
      cmd(8'd8, OP_CLEAR, 4'd0, 32'h4);
      rd("clr_lo", OP_READ_LO, 4'd2, 32'd0);
      rd("clr_st", OP_STATUS, 4'd0, 32'h0000_0004);
      rd("hi_zero", OP_READ_HI, 4'd2, 32'd0);
      rd("oob_lo", OP_READ_LO, 4'd5, 32'd0);
      cmd(8'd8, OP_DISABLE, 4'd0, 32'h4);

      // snapshot counter3 at 20, then 50 idle cycles
      cmd(8'd8, OP_ENABLE, 4'd0, 32'h8);
      repeat (20) @(negedge clock);
      cmd(8'd8, OP_SNAPSHOT, 4'd0, 32'h0);
      chk("snap_dn", 32'(d_s), 32'd1);
      chk("snap_res", r_s, 32'd0);
      repeat (50) @(negedge clock);
      rd("snap_live", OP_READ_LO, 4'd3, 32'd71);
`ifdef PROFILE_CI_SNAPSHOT_EN
      rd("snap_shd", OP_READ_SHADOW, 4'd3, 32'd20);
`else
      rd("snap_shd", OP_READ_SHADOW, 4'd3, 32'd72);
`endif
      cmd(8'd8, OP_DISABLE, 4'd0, 32'h8);

      // foreign ciN and reserved opcode
      cmd(8'd9, OP_ENABLE, 4'd0, 32'h1);
      chk("foreign_dn", 32'(d_s), 32'd0);
      chk("foreign_res", r_s, 32'd0);
      cmd(8'd8, 4'd12, 4'd0, 32'hF);
      chk("rsv_dn", 32'(d_s), 32'd1);
      chk("rsv_res", r_s, 32'd0);
      rd("rsv_st", OP_STATUS, 4'd0, 32'h0);
      rd("hold_lo", OP_READ_LO, 4'd0, 32'd3);

      // reset on the accepting edge wins
      start = 1'b1; ciN = 8'd8; valueA = {24'h0, OP_READ_LO, 4'd1}; reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("rstcmd_dn", 32'(done), 32'd0);
      chk("rstcmd_res", result, 32'd0);
      start = 1'b0; ciN = '0; valueA = '0; reset = 1'b0;
      rd("rstcmd_lo", OP_READ_LO, 4'd1, 32'd0);
      rd("rstcmd_st", OP_STATUS, 4'd0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
